mem_bus_initiator: RTL and testbench
====================================

// Module: mem_bus_initiator
// PURPOSE
//  CPU-side initiator for the KS-10 memory bus; the memory array is the responder on the far end.
//  Turns one CPU cycle request (read, write or read-modify-write) into bus transactions.
//  Drives request, address/flag word and write data; waits for ack; returns read data.
//  Bounded ack timeout yields non-existent-memory (NXM) status instead of hanging.
// PARAMETERS
//  TIMEOUT      15  clken cycles without busACKI before NXM is declared (1..2**TOW-1)
//  TOW          4   width of timeout counter
// PORTS
//  clk        in   1   clock; all state changes on posedge clk
//  rst_n      in   1   asynchronous reset, active low
//  clken      in   1   clock enable; state advances only on clk edges with clken=1
//  cpuREQ     in   1   start request, sampled in IDLE when clken=1
//  cpuREAD    in   1   read requested (READ&WRITE = read-modify-write)
//  cpuWRITE   in   1   write requested
//  cpuIO      in   1   IO-space cycle (copied to flag bit 10)
//  cpuADDR    in   22  physical address, placed on busADDRO[14:35]
//  cpuDATA    in   36  write data (plain write: at cpuREQ; RMW: at cpuWVALID)
//  cpuWVALID  in   1   RMW write data valid; accepted only in RMWHOLD
//  cpuBUSY    out  1   1 from the edge that accepts cpuREQ until the completing edge
//  cpuDONE    out  1   one-clk pulse: cycle complete (also asserted with cpuNXM)
//  cpuNXM     out  1   one-clk pulse: ack timeout
//  cpuRDATA   out  36  read data, held until next read completes
//  busREQO    out  1   bus request
//  busACKI    in   1   responder acknowledge (combinational from address)
//  busADDRO   out  36  [0:13] flags (bit3 READ, bit5 WRITE, bit10 IO, others 0), [14:35] addr
//  busDATAO   out  36  write data to responder
//  busDATAI   in   36  read data from responder
// BEHAVIOUR
//  Reset: state IDLE; every output 0; counter 0; latched address/flags/data 0. Takes effect
//   immediately, mid-transaction included; in-flight cycle is dropped with no cpuDONE.
//  clken=0: state, counter and outputs are held. Any pending cpuDONE/cpuNXM pulse still clears
//   after one clk.
//  All outputs are registered. busADDRO and busDATAO are 0 whenever busREQO=0.
//   Reason: the responder writes on WRITE flag alone, without qualifying on request.
//  IDLE: cpuREQ&clken latches addr, io, rw and cpuDATA, clears the counter, and sets cpuBUSY.
//   Goes to RDREQ if cpuREAD, else WRREQ if cpuWRITE.
//   cpuREQ with neither READ nor WRITE: ignored; stays IDLE; no pulse.
//   cpuREQ while BUSY: ignored, no queuing.
//  RDREQ: busREQO=1, flag bit3=1, bit5=0 (RMW read phase included), bit10=io.
//   Each clken edge with busACKI=1: cpuRDATA<=busDATAI.
//    RMW: go to RMWHOLD, counter cleared.
//    Otherwise: cpuDONE pulse, BUSY=0, go to IDLE.
//   busACKI=0: counter+1; the edge where the counter would reach TIMEOUT gives cpuNXM+cpuDONE.
//    cpuRDATA<=0; go to IDLE; an RMW is aborted with no write phase.
//  RMWHOLD: busREQO=0, busADDRO=0, no timeout.
//   cpuWVALID&clken latches cpuDATA; go to WRREQ, counter cleared.
//  WRREQ: busREQO=1, flag bit5=1, bit3=0, bit10=io, busDATAO=latched data.
//   Ack gives cpuDONE and goes to IDLE. Timeout as in RDREQ; cpuRDATA unchanged.
//  Latency: ack in first request cycle -> cpuDONE one clk after that edge.
//   Read: 2 clken edges from cpuREQ to DONE.
//  Ack and timeout on the same edge: ack wins.
//  Counter saturates and never wraps. Address is not incremented; each request is one word.
// TESTING
//  Read, ack at once: addr 0o001000, busDATAI=0o123456701234.
//   -> busREQO 1 cycle, busADDRO[3]=1, busADDRO[5]=0; cpuRDATA=0o123456701234; DONE=1, NXM=0.
//  Write to NXM: addr 0o100000, busACKI held 0.
//   -> busADDRO[5]=1 for 15 clken cycles; then cpuNXM=cpuDONE=1 one clk; busREQO=0, busADDRO=0.
//  RMW: read returns 0o1, cpuWVALID with 0o777777000000 five cycles later.
//   -> busREQO=0 during hold; write phase bit5=1, busDATAO=0o777777000000; one DONE only.
//  clken 1-in-3 with no ack on read -> NXM after exactly 45 clk; outputs stable between enables.
//  rst_n low mid-RDREQ -> busREQO, busADDRO, cpuBUSY 0 without clk; no DONE after release.
//  Ignored requests: cpuREQ while BUSY, and cpuREQ with READ=WRITE=0.
//   -> no extra bus cycle, no pulse; IO read sets busADDRO[10]=1.

Source files
------------

// File: rtl/mem_bus_if.sv
// KS-10 memory bus between the CPU-side initiator (master) and the memory array (slave).
// 36-bit words are stored [35:0]; KS-10 bit n sits at index 35-n.
interface mem_bus_if;
   logic        busREQO;
   logic        busACKI;
   logic [35:0] busADDRO;
   logic [35:0] busDATAO;
   logic [35:0] busDATAI;

   modport master (output busREQO, busADDRO, busDATAO, input busACKI, busDATAI);
   modport slave  (input busREQO, busADDRO, busDATAO, output busACKI, busDATAI);
endinterface

// File: rtl/mem_bus_initiator.sv
// CPU-side KS-10 memory bus initiator: read, write and read-modify-write with ack timeout (NXM).
// KS-10 bit n maps to index 35-n: READ flag bit3 -> [32], WRITE bit5 -> [30], IO bit10 -> [25], addr -> [21:0].
module mem_bus_initiator #(
   parameter int TIMEOUT = 15,
   parameter int TOW     = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clken,
   input  logic        cpuREQ,
   input  logic        cpuREAD,
   input  logic        cpuWRITE,
   input  logic        cpuIO,
   input  logic [21:0] cpuADDR,
   input  logic [35:0] cpuDATA,
   input  logic        cpuWVALID,
   output logic        cpuBUSY,
   output logic        cpuDONE,
   output logic        cpuNXM,
   output logic [35:0] cpuRDATA,
   mem_bus_if.master   bus
);

   localparam int FLAG_READ  = 32;
   localparam int FLAG_WRITE = 30;
   localparam int FLAG_IO    = 25;

   typedef enum logic [1:0] {IDLE, RDREQ, RMWHOLD, WRREQ} state_t;

   state_t      state, stateNxt;
   logic [TOW-1:0] cnt, cntNxt;
   logic [21:0] addrQ, addrNxt;
   logic        ioQ, ioNxt, rmwQ, rmwNxt;
   logic [35:0] dataQ, dataNxt, rdataNxt, addrWordNxt;
   logic        doneNxt, nxmNxt, reqNxt, timedOut;

   // Counter holds the number of unacked edges already seen; this edge would be the TIMEOUT-th.
   assign timedOut = (cnt == TOW'(TIMEOUT - 1));

   always_comb begin
      stateNxt    = state;
      cntNxt      = cnt;
      addrNxt     = addrQ;
      ioNxt       = ioQ;
      rmwNxt      = rmwQ;
      dataNxt     = dataQ;
      rdataNxt    = cpuRDATA;
      doneNxt     = 1'b0;
      nxmNxt      = 1'b0;
      reqNxt      = 1'b0;
      addrWordNxt = '0;
      case (state)
         IDLE: begin
            if (cpuREQ && (cpuREAD || cpuWRITE)) begin
               addrNxt  = cpuADDR;
               ioNxt    = cpuIO;
               rmwNxt   = cpuREAD && cpuWRITE;
               dataNxt  = cpuDATA;
               cntNxt   = '0;
               stateNxt = cpuREAD ? RDREQ : WRREQ;
            end
         end
         RDREQ: begin
            if (bus.busACKI) begin
               rdataNxt = bus.busDATAI;
               cntNxt   = '0;
               if (rmwQ) stateNxt = RMWHOLD;
               else begin
                  doneNxt  = 1'b1;
                  stateNxt = IDLE;
               end
            end else if (timedOut) begin
               doneNxt  = 1'b1;
               nxmNxt   = 1'b1;
               rdataNxt = '0;
               stateNxt = IDLE;
            end else cntNxt = cnt + TOW'(1);
         end
         RMWHOLD: begin
            if (cpuWVALID) begin
               dataNxt  = cpuDATA;
               cntNxt   = '0;
               stateNxt = WRREQ;
            end
         end
         WRREQ: begin
            if (bus.busACKI) begin
               doneNxt  = 1'b1;
               stateNxt = IDLE;
            end else if (timedOut) begin
               doneNxt  = 1'b1;
               nxmNxt   = 1'b1;
               stateNxt = IDLE;
            end else cntNxt = cnt + TOW'(1);
         end
         default: stateNxt = IDLE;
      endcase
      // Address/data words are zero off-request: the responder writes on the WRITE flag alone.
      reqNxt = (stateNxt == RDREQ) || (stateNxt == WRREQ);
      if (reqNxt) begin
         addrWordNxt[21:0]       = addrNxt;
         addrWordNxt[FLAG_READ]  = (stateNxt == RDREQ);
         addrWordNxt[FLAG_WRITE] = (stateNxt == WRREQ);
         addrWordNxt[FLAG_IO]    = ioNxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         addrQ        <= '0;
         ioQ          <= 1'b0;
         rmwQ         <= 1'b0;
         dataQ        <= '0;
         cpuBUSY      <= 1'b0;
         cpuDONE      <= 1'b0;
         cpuNXM       <= 1'b0;
         cpuRDATA     <= '0;
         bus.busREQO  <= 1'b0;
         bus.busADDRO <= '0;
         bus.busDATAO <= '0;
      end else begin
         // Pulses clear on the next clk even with clken low.
         cpuDONE <= clken & doneNxt;
         cpuNXM  <= clken & nxmNxt;
         if (clken) begin
            state        <= stateNxt;
            cnt          <= cntNxt;
            addrQ        <= addrNxt;
            ioQ          <= ioNxt;
            rmwQ         <= rmwNxt;
            dataQ        <= dataNxt;
            cpuBUSY      <= (stateNxt != IDLE);
            cpuRDATA     <= rdataNxt;
            bus.busREQO  <= reqNxt;
            bus.busADDRO <= addrWordNxt;
            bus.busDATAO <= (stateNxt == WRREQ) ? dataNxt : '0;
         end
      end
   end

endmodule

// File: tb/tb_mem_bus_initiator.sv
// Randomized scoreboard bench for mem_bus_initiator against a word-level memory model.
module tb_mem_bus_initiator;
   localparam int TIMEOUT = 15;

   typedef struct { logic nxm; logic [35:0] rdata; } exp_t;

   logic clk = 1'b0, rst_n = 1'b0, clken = 1'b0;
   logic cpuREQ = 0, cpuREAD = 0, cpuWRITE = 0, cpuIO = 0, cpuWVALID = 0;
   logic [21:0] cpuADDR = '0;
   logic [35:0] cpuDATA = '0, cpuRDATA;
   logic cpuBUSY, cpuDONE, cpuNXM;

   mem_bus_if bus();

   mem_bus_initiator #(.TIMEOUT(TIMEOUT), .TOW(4)) dut (
      .clk(clk), .rst_n(rst_n), .clken(clken),
      .cpuREQ(cpuREQ), .cpuREAD(cpuREAD), .cpuWRITE(cpuWRITE), .cpuIO(cpuIO),
      .cpuADDR(cpuADDR), .cpuDATA(cpuDATA), .cpuWVALID(cpuWVALID),
      .cpuBUSY(cpuBUSY), .cpuDONE(cpuDONE), .cpuNXM(cpuNXM), .cpuRDATA(cpuRDATA),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0;
   int clkMode = 0, ackDly = 0, reqAge = 0;
   logic lastEn = 1'b0;
   exp_t sbq[$];
   logic [35:0] refMem [64];
   logic [35:0] lastRd = '0;
   logic [21:0] curAddr = '0;
   logic curIo = 0, curPhW = 0;
   logic [35:0] curWdata = '0;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, expv, $time);
      end
   endtask

   task automatic flag(input string nm, input logic [127:0] act);
      total++;
      bad++;
      $display("FAIL %s act=%0h t=%0t", nm, act, $time);
   endtask

   function automatic logic [35:0] initWord(input logic [5:0] i);
      return 36'o123456701234 ^ ({30'd0, i} * 36'd7777);
   endfunction

   function automatic logic [35:0] rand36();
      return {4'($urandom), $urandom};
   endfunction

   // Responder: memory window 0o001000..0o001077, ack after ackDly enabled edges of request.
   logic [35:0] respMem [64];
   bit          respVld [64];
   logic [5:0]  rspIx;
   logic        rspOk;
   assign rspIx = bus.busADDRO[5:0];
   assign rspOk = (bus.busADDRO[21:0] >= 22'o001000) && (bus.busADDRO[21:0] <= 22'o001077);
   assign bus.busACKI  = bus.busREQO && rspOk && (reqAge >= ackDly);
   assign bus.busDATAI = (bus.busREQO && rspOk) ? (respVld[rspIx] ? respMem[rspIx] : initWord(rspIx)) : '0;

   always @(posedge clk) begin
      if (clken) reqAge <= bus.busREQO ? reqAge + 1 : 0;
      if (clken && bus.busREQO && bus.busADDRO[30] && bus.busACKI) begin
         respMem[rspIx] <= bus.busDATAO;
         respVld[rspIx] <= 1'b1;
      end
   end

   // Clock enable: always on, or 1-in-3.
   initial begin : clkenGen
      int ph = 0;
      forever begin
         @(negedge clk);
         if (clkMode == 0) clken = 1'b1;
         else begin
            clken = (ph == 0);
            ph = (ph == 2) ? 0 : ph + 1;
         end
      end
   end

   initial forever begin
      @(posedge clk);
      lastEn = clken;
   end

   function automatic logic [35:0] expAddr(input logic [21:0] a, input logic io, input logic wr);
      logic [35:0] w;
      w = '0;
      w[21:0] = a;
      w[25] = io;
      if (wr) w[30] = 1'b1;
      else    w[32] = 1'b1;
      return w;
   endfunction

   function automatic logic [109:0] outSnap();
      return {bus.busREQO, bus.busADDRO, bus.busDATAO, cpuBUSY, cpuRDATA};
   endfunction

   // Monitor: bus word checks, hold-stability with clken low, and completion scoreboard.
   initial begin : mon
      exp_t e;
      logic [109:0] snap;
      snap = '0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (!bus.busREQO) check("bus_idle_zero", {bus.busADDRO, bus.busDATAO}, '0);
            else begin
               check("bus_addr", bus.busADDRO, expAddr(curAddr, curIo, curPhW));
               if (curPhW) check("bus_wdata", bus.busDATAO, curWdata);
            end
            if (!lastEn) check("hold_stable", outSnap(), snap);
            if (cpuNXM) check("nxm_with_done", cpuDONE, 1'b1);
            if (cpuDONE) begin
               if (sbq.size() == 0) flag("unexpected_done", cpuRDATA);
               else begin
                  e = sbq.pop_front();
                  check("done_nxm", cpuNXM, e.nxm);
                  check("done_rdata", cpuRDATA, e.rdata);
               end
            end
         end
         snap = outSnap();
      end
   end

   task automatic waitEn();
      int n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!clken && n < 10);
   endtask

   // kind: 0 read, 1 write, 2 read-modify-write. Called at posedge+1.
   task automatic doOp(input int kind, input logic [21:0] a, input logic io,
                       input logic [35:0] d1, input logic [35:0] d2, input int hold);
      exp_t e;
      logic ok, fin, wvOn, wvDone;
      logic [5:0] ix;
      int lat, expLat, hc;
      ok = (a >= 22'o001000) && (a <= 22'o001077) && (ackDly <= TIMEOUT - 1);
      ix = 6'(a - 22'o001000);
      case (kind)
         0: begin
            lastRd = ok ? refMem[ix] : '0;
            e = '{nxm: !ok, rdata: lastRd};
         end
         1: begin
            if (ok) refMem[ix] = d1;
            e = '{nxm: !ok, rdata: lastRd};
         end
         default: begin
            lastRd = ok ? refMem[ix] : '0;
            if (ok) refMem[ix] = d2;
            e = '{nxm: !ok, rdata: lastRd};
         end
      endcase
      sbq.push_back(e);
      expLat = (ok ? ackDly + 1 : TIMEOUT) * (clkMode ? 3 : 1);
      curAddr = a; curIo = io; curWdata = d1; curPhW = (kind == 1);
      cpuREQ = 1; cpuREAD = (kind != 1); cpuWRITE = (kind != 0);
      cpuIO = io; cpuADDR = a; cpuDATA = d1;
      waitEn();
      cpuREQ = 0; cpuREAD = 0; cpuWRITE = 0; cpuIO = 0; cpuDATA = rand36();
      lat = 0; fin = 0; wvOn = 0; wvDone = 0; hc = 0;
      for (int n = 0; n < 4000 && !fin; n++) begin
         @(posedge clk); #1;
         lat++;
         if (wvOn && clken) begin
            cpuWVALID = 0; cpuDATA = rand36(); wvOn = 0;
         end
         if (n == 1) begin
            cpuREQ = 0; cpuREAD = 0; cpuWRITE = 0;
         end
         if (cpuDONE) fin = 1;
         else begin
            // A request while busy must be ignored.
            if (n == 0 && cpuBUSY) begin
               cpuREQ = 1; cpuREAD = 1'($urandom_range(0, 1)); cpuWRITE = 1;
            end
            if (kind == 2 && !wvDone && cpuBUSY && !bus.busREQO) begin
               if (hc == hold) begin
                  cpuWVALID = 1; cpuDATA = d2; curWdata = d2; curPhW = 1; wvOn = 1; wvDone = 1;
               end
               hc++;
            end
         end
      end
      cpuWVALID = 0; cpuREQ = 0; cpuREAD = 0; cpuWRITE = 0;
      if (!fin) flag("op_no_done", lat);
      if (kind != 2) check("latency", lat, expLat);
      check("idle_after_done", {cpuBUSY, bus.busREQO}, 2'b00);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) refMem[i] = initWord(6'(i));
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", cpuBUSY, 0);
      check("rst_done", {cpuDONE, cpuNXM}, 0);
      check("rst_rdata", cpuRDATA, 0);
      check("rst_bus", {bus.busREQO, bus.busADDRO, bus.busDATAO}, 0);
      rst_n = 1;
      repeat (2) @(posedge clk);
      #1;

      // Read with immediate ack, then write to non-existent memory.
      doOp(0, 22'o001000, 0, '0, '0, 0);
      check("first_read_value", cpuRDATA, 36'o123456701234);
      doOp(1, 22'o100000, 0, 36'o555555555555, '0, 0);
      // RMW: read returns 1, write phase with data five cycles later, then read back.
      doOp(1, 22'o001005, 0, 36'o1, '0, 0);
      doOp(2, 22'o001005, 0, '0, 36'o777777000000, 5);
      doOp(0, 22'o001005, 0, '0, '0, 0);
      // Ack on the last edge before timeout wins; one edge later is NXM.
      ackDly = 14; doOp(0, 22'o001010, 0, '0, '0, 0);
      ackDly = 15; doOp(0, 22'o001011, 0, '0, '0, 0);
      ackDly = 0;
      // 1-in-3 enable.
      clkMode = 1;
      doOp(0, 22'o123456, 0, '0, '0, 0);
      doOp(0, 22'o001012, 0, '0, '0, 0);
      clkMode = 0;
      // IO read.
      doOp(0, 22'o001013, 1, '0, '0, 0);

      // Request with neither read nor write.
      cpuREQ = 1; cpuADDR = 22'o001014;
      waitEn();
      cpuREQ = 0;
      repeat (2) @(posedge clk);
      #1;
      check("noop_req_idle", {cpuBUSY, bus.busREQO}, 0);

      // Reset mid read request to NXM.
      curAddr = 22'o100001; curIo = 0; curPhW = 0;
      cpuREQ = 1; cpuREAD = 1; cpuADDR = 22'o100001;
      waitEn();
      cpuREQ = 0; cpuREAD = 0;
      repeat (3) @(posedge clk);
      #3 rst_n = 0;
      #1;
      check("async_rst_req", bus.busREQO, 0);
      check("async_rst_addr", bus.busADDRO, 0);
      check("async_rst_busy", cpuBUSY, 0);
      lastRd = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      repeat (25) @(posedge clk);
      #1;
      check("post_rst_rdata", cpuRDATA, lastRd);
      check("post_rst_idle", {cpuBUSY, bus.busREQO}, 0);

      // Random mix.
      for (int i = 0; i < 60; i++) begin
         int dsel, k;
         logic [21:0] a;
         clkMode = ($urandom_range(0, 3) == 0);
         dsel = $urandom_range(0, 7);
         ackDly = (dsel < 3) ? 0 : (dsel == 3) ? 1 : (dsel == 4) ? 3 : (dsel == 5) ? 14 : (dsel == 6) ? 15 : 20;
         k = $urandom_range(0, 2);
         a = ($urandom_range(0, 4) != 0) ? 22'(22'o001000 + $urandom_range(0, 63))
                                         : 22'(22'o100000 + $urandom_range(0, 255));
         doOp(k, a, 1'($urandom_range(0, 1)), rand36(), rand36(), $urandom_range(0, 6));
      end
      clkMode = 0;
      repeat (5) @(posedge clk);
      #1;
      check("scoreboard_drained", sbq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      flag("global_time_limit", 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "time limit");
   end
endmodule
